// File: rtl/arcade_input_conditioner_if.sv
// Handshake-free input/output bundle for arcade_input_conditioner.
// master drives raw inputs, slave is the conditioner itself.
interface arcade_input_conditioner_if;
  logic [10:0] ps2_key;
  logic [15:0] joy;
  logic        autofire_en;
  logic [4:0]  p1_ctrl;
  logic [4:0]  p2_ctrl;
  logic        start1;
  logic        start2;
  logic        coin_out;
  logic        coin_busy;
  logic [7:0]  coin_count;

  modport master (
    output ps2_key, joy, autofire_en,
    input  p1_ctrl, p2_ctrl, start1, start2,
    input  coin_out, coin_busy, coin_count
  );

  modport slave (
    input  ps2_key, joy, autofire_en,
    output p1_ctrl, p2_ctrl, start1, start2,
    output coin_out, coin_busy, coin_count
  );
endinterface

// File: rtl/arcade_input_conditioner.sv
// arcade_input_conditioner: ps2 keys + joystick -> core controls, coin shaper.
// Optional autofire gating of fire bits when INPUT_AUTOFIRE_EN is defined.
module arcade_input_conditioner #(
  parameter int COIN_PULSE_CYC   = 2000000,
  parameter int COIN_HOLDOFF_CYC = 4000000,
  parameter int AUTOFIRE_DIV     = 4000000
) (
  input logic clk_sys,
  input logic reset,
  arcade_input_conditioner_if.slave bus
);

  localparam int K_UP1    = 0;
  localparam int K_DOWN1  = 1;
  localparam int K_LEFT1  = 2;
  localparam int K_RIGHT1 = 3;
  localparam int K_FIRE1  = 4;
  localparam int K_START1 = 5;
  localparam int K_START2 = 6;
  localparam int K_COINA  = 7;
  localparam int K_COINB  = 8;
  localparam int K_UP2    = 9;
  localparam int K_DOWN2  = 10;
  localparam int K_LEFT2  = 11;
  localparam int K_RIGHT2 = 12;
  localparam int K_FIRE2  = 13;

  localparam logic [22:0] PULSE_LD = 23'(COIN_PULSE_CYC - 1);
  localparam logic [22:0] HOLD_LD  = 23'(COIN_HOLDOFF_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_HOLD,
    S_WREL
  } state_t;

  logic        old_tgl_q;
  logic [13:0] key_q;
  logic [13:0] key_d;
  logic        evt;
  logic        pr;
  logic        ext;
  logic [7:0]  code;

  logic [4:0]  p1_q;
  logic [4:0]  p2_q;
  logic        s1_q;
  logic        s2_q;
  logic        p1_fire;
  logic        p2_fire;
  logic        p1_fire_raw;
  logic        p2_fire_raw;

  logic        coin_raw;
  logic        coin_raw_q;
  logic        coin_dly_q;
  logic        coin_rise;
  state_t      state_q;
  logic [22:0] cnt_q;
  logic        coin_out_q;
  logic        busy_q;
  logic [7:0]  count_q;

  logic        unused_ok;
  assign unused_ok = ^{1'b0, bus.joy[15:8]};

  assign evt  = bus.ps2_key[10] != old_tgl_q;
  assign pr   = bus.ps2_key[9];
  assign ext  = bus.ps2_key[8];
  assign code = bus.ps2_key[7:0];

  // Scancode decode: arrow keys match with or without the E0 prefix.
  always_comb begin
    key_d = key_q;
    if (evt) begin
      case (code)
        8'h75: key_d[K_UP1] = pr;
        8'h72: key_d[K_DOWN1] = pr;
        8'h6B: key_d[K_LEFT1] = pr;
        8'h74: key_d[K_RIGHT1] = pr;
        8'h29: if (!ext) key_d[K_FIRE1] = pr;
        8'h14: if (!ext) key_d[K_FIRE1] = pr;
        8'h05: if (!ext) key_d[K_START1] = pr;
        8'h16: if (!ext) key_d[K_START1] = pr;
        8'h06: if (!ext) key_d[K_START2] = pr;
        8'h1E: if (!ext) key_d[K_START2] = pr;
        8'h2E: if (!ext) key_d[K_COINA] = pr;
        8'h36: if (!ext) key_d[K_COINB] = pr;
        8'h2D: if (!ext) key_d[K_UP2] = pr;
        8'h2B: if (!ext) key_d[K_DOWN2] = pr;
        8'h23: if (!ext) key_d[K_LEFT2] = pr;
        8'h34: if (!ext) key_d[K_RIGHT2] = pr;
        8'h1C: if (!ext) key_d[K_FIRE2] = pr;
        default: ;
      endcase
    end
  end

  // Held-key state; toggle is resynced in reset so no phantom event.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      old_tgl_q <= bus.ps2_key[10];
      key_q     <= '0;
    end else begin
      old_tgl_q <= bus.ps2_key[10];
      key_q     <= key_d;
    end
  end

  assign p1_fire_raw = key_q[K_FIRE1] | bus.joy[4];
  assign p2_fire_raw = key_q[K_FIRE2] | bus.joy[4];

`ifdef INPUT_AUTOFIRE_EN
  logic        phase_q;
  logic [31:0] af_cnt_q;
  logic        any_fire;

  assign any_fire = p1_fire_raw | p2_fire_raw;

  // Autofire phase: starts "on" so the first press fires at once.
  always_ff @(posedge clk_sys) begin
    if (reset || !any_fire) begin
      phase_q  <= 1'b1;
      af_cnt_q <= '0;
    end else if (af_cnt_q == 32'(AUTOFIRE_DIV - 1)) begin
      phase_q  <= ~phase_q;
      af_cnt_q <= '0;
    end else begin
      af_cnt_q <= af_cnt_q + 32'd1;
    end
  end

  assign p1_fire = p1_fire_raw & (~bus.autofire_en | phase_q);
  assign p2_fire = p2_fire_raw & (~bus.autofire_en | phase_q);
`else
  logic unused_af;
  assign unused_af = bus.autofire_en;
  assign p1_fire   = p1_fire_raw;
  assign p2_fire   = p2_fire_raw;
`endif

  // Registered player/start outputs: keys OR'd with joystick.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      p1_q <= '0;
      p2_q <= '0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      p1_q <= {p1_fire,
               key_q[K_UP1] | bus.joy[3],
               key_q[K_DOWN1] | bus.joy[2],
               key_q[K_LEFT1] | bus.joy[1],
               key_q[K_RIGHT1] | bus.joy[0]};
      p2_q <= {p2_fire,
               key_q[K_UP2] | bus.joy[3],
               key_q[K_DOWN2] | bus.joy[2],
               key_q[K_LEFT2] | bus.joy[1],
               key_q[K_RIGHT2] | bus.joy[0]};
      s1_q <= key_q[K_START1] | bus.joy[5];
      s2_q <= key_q[K_START2] | bus.joy[6];
    end
  end

  assign coin_raw  = key_q[K_COINA] | key_q[K_COINB] | bus.joy[7];
  assign coin_rise = coin_raw_q & ~coin_dly_q;

  // Coin request register and its delayed copy for edge detect.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      coin_raw_q <= 1'b0;
      coin_dly_q <= 1'b0;
    end else begin
      coin_raw_q <= coin_raw;
      coin_dly_q <= coin_raw_q;
    end
  end

  // Coin FSM: one fixed pulse, holdoff, then wait for release.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      coin_out_q <= 1'b0;
      busy_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (coin_rise) begin
            state_q    <= S_PULSE;
            cnt_q      <= PULSE_LD;
            coin_out_q <= 1'b1;
            busy_q     <= 1'b1;
            count_q    <= count_q + 8'd1;
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            state_q    <= S_HOLD;
            cnt_q      <= HOLD_LD;
            coin_out_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 23'd1;
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            if (coin_raw_q) begin
              state_q <= S_WREL;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 23'd1;
          end
        end
        S_WREL: begin
          if (!coin_raw_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.p1_ctrl    = p1_q;
  assign bus.p2_ctrl    = p2_q;
  assign bus.start1     = s1_q;
  assign bus.start2     = s2_q;
  assign bus.coin_out   = coin_out_q;
  assign bus.coin_busy  = busy_q;
  assign bus.coin_count = count_q;

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Bench for arcade_input_conditioner: random control traffic vs model,
// coin pulse/holdoff/reset scenarios, autofire cadence.
module tb_arcade_input_conditioner;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  arcade_input_conditioner_if bus_if ();

  arcade_input_conditioner #(
    .COIN_PULSE_CYC  (4),
    .COIN_HOLDOFF_CYC(8),
    .AUTOFIRE_DIV    (3)
  ) dut (
    .clk_sys(clk),
    .reset  (reset),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic p, input logic e,
                          input logic [7:0] c);
    bus_if.ps2_key = {~bus_if.ps2_key[10], p, e, c};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.joy = '0;
    bus_if.autofire_en = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Function index per spec key map: 0 up1,1 down1,2 left1,3 right1,
  // 4 fire1,5 start1,6 start2,7 coinA,8 coinB,9 up2,10 down2,
  // 11 left2,12 right2,13 fire2; -1 when unmapped.
  function automatic int key_fn(input logic [7:0] c, input logic e);
    case (c)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: ;
    endcase
    if (e) return -1;
    case (c)
      8'h29, 8'h14: return 4;
      8'h05, 8'h16: return 5;
      8'h06, 8'h1E: return 6;
      8'h2E: return 7;
      8'h36: return 8;
      8'h2D: return 9;
      8'h2B: return 10;
      8'h23: return 11;
      8'h34: return 12;
      8'h1C: return 13;
      default: return -1;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus_if.joy = 16'h00FF;
    bus_if.ps2_key = {1'b1, 1'b1, 1'b1, 8'h75};
    step();
    step();
    bus_if.joy = '0;
    step();
    checks++;
    if ({bus_if.p1_ctrl, bus_if.p2_ctrl} !== 10'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {bus_if.p1_ctrl, bus_if.p2_ctrl});
    end
    checks++;
    if ({bus_if.start1, bus_if.start2, bus_if.coin_out,
         bus_if.coin_busy} !== 4'd0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0",
               {bus_if.start1, bus_if.start2,
                bus_if.coin_out, bus_if.coin_busy});
    end
    checks++;
    if (bus_if.coin_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0",
               bus_if.coin_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bus_if.p1_ctrl !== 5'd0) begin
      errors++;
      $display("FAIL reset_no_event: got %b expected 0",
               bus_if.p1_ctrl);
    end
  endtask

  task automatic test_key_up();
    do_reset();
    send_key(1'b1, 1'b1, 8'h75);
    step();
    checks++;
    if (bus_if.p1_ctrl !== 5'b00000) begin
      errors++;
      $display("FAIL key_lat1: got %b expected 00000", bus_if.p1_ctrl);
    end
    step();
    checks++;
    if (bus_if.p1_ctrl !== 5'b01000) begin
      errors++;
      $display("FAIL key_up: got %b expected 01000", bus_if.p1_ctrl);
    end
    send_key(1'b0, 1'b1, 8'h75);
    step();
    step();
    checks++;
    if (bus_if.p1_ctrl !== 5'b00000) begin
      errors++;
      $display("FAIL key_rel: got %b expected 00000", bus_if.p1_ctrl);
    end
  endtask

  task automatic test_random_ctrl();
    logic [7:0] codes [20];
    logic [13:0] mk;
    logic [4:0] e1;
    logic [4:0] e2;
    logic es1;
    logic es2;
    logic [15:0] j;
    int f;
    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05,
              8'h16, 8'h06, 8'h1E, 8'h2D, 8'h2B, 8'h23, 8'h34,
              8'h1C, 8'h11, 8'h55, 8'h4A, 8'h29, 8'h1C};
    do_reset();
    mk = '0;
    for (int t = 0; t < 300; t++) begin
      j = 16'($urandom);
      j[7] = 1'b0;
      bus_if.joy = j;
      e1 = {mk[4] | j[4], mk[0] | j[3], mk[1] | j[2],
            mk[2] | j[1], mk[3] | j[0]};
      e2 = {mk[13] | j[4], mk[9] | j[3], mk[10] | j[2],
            mk[11] | j[1], mk[12] | j[0]};
      es1 = mk[5] | j[5];
      es2 = mk[6] | j[6];
      if ($urandom_range(2) == 0) begin
        logic [7:0] c;
        logic p;
        logic e;
        c = codes[$urandom_range(19)];
        p = 1'($urandom);
        e = (key_fn(c, 1'b0) inside {[0:3]}) ? 1'($urandom) : 1'b0;
        send_key(p, e, c);
        f = key_fn(c, e);
        if (f >= 0) mk[f] = p;
      end
      step();
      checks++;
      if ({bus_if.p1_ctrl, bus_if.p2_ctrl, bus_if.start1,
           bus_if.start2} !== {e1, e2, es1, es2}) begin
        errors++;
        $display("FAIL rand_ctrl t=%0d: got %b expected %b", t,
                 {bus_if.p1_ctrl, bus_if.p2_ctrl,
                  bus_if.start1, bus_if.start2},
                 {e1, e2, es1, es2});
      end
    end
  endtask

  task automatic test_coin_hold();
    int highs;
    int rises;
    int first;
    logic prev;
    do_reset();
    highs = 0;
    rises = 0;
    first = -1;
    prev = 1'b0;
    bus_if.joy = 16'h0080;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_if.coin_out) highs++;
      if (bus_if.coin_out && !prev) begin
        rises++;
        if (first < 0) first = i;
      end
      prev = bus_if.coin_out;
    end
    checks++;
    if (highs !== 4 || rises !== 1) begin
      errors++;
      $display("FAIL coin_hold_pulse: got %0d high/%0d pulses expected 4/1",
               highs, rises);
    end
    checks++;
    if (!(first inside {0, 1})) begin
      errors++;
      $display("FAIL coin_hold_latency: got %0d expected 0..1", first);
    end
    checks++;
    if (bus_if.coin_count !== 8'd1 || bus_if.coin_busy !== 1'b1) begin
      errors++;
      $display("FAIL coin_hold_state: got count %0d busy %b expected 1/1",
               bus_if.coin_count, bus_if.coin_busy);
    end
    bus_if.joy = '0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bus_if.coin_busy !== 1'b0 || bus_if.coin_count !== 8'd1) begin
      errors++;
      $display("FAIL coin_release: got busy %b count %0d expected 0/1",
               bus_if.coin_busy, bus_if.coin_count);
    end
  endtask

  task automatic coin_tap(input int hi, input int lo, inout int rises);
    logic prev;
    prev = bus_if.coin_out;
    for (int i = 0; i < hi + lo; i++) begin
      bus_if.joy = (i < hi) ? 16'h0080 : 16'h0000;
      step();
      if (bus_if.coin_out && !prev) rises++;
      prev = bus_if.coin_out;
    end
  endtask

  task automatic test_holdoff();
    int rises;
    do_reset();
    rises = 0;
    coin_tap(2, 4, rises);
    coin_tap(2, 24, rises);
    checks++;
    if (rises !== 1 || bus_if.coin_count !== 8'd1) begin
      errors++;
      $display("FAIL holdoff: got %0d pulses count %0d expected 1/1",
               rises, bus_if.coin_count);
    end
    checks++;
    if (bus_if.coin_busy !== 1'b0) begin
      errors++;
      $display("FAIL holdoff_idle: got busy %b expected 0",
               bus_if.coin_busy);
    end
    rises = 0;
    coin_tap(2, 20, rises);
    checks++;
    if (rises !== 1 || bus_if.coin_count !== 8'd2) begin
      errors++;
      $display("FAIL third_coin: got %0d pulses count %0d expected 1/2",
               rises, bus_if.coin_count);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int n;
    do_reset();
    bus_if.joy = 16'h0080;
    n = 0;
    while (!bus_if.coin_out && n < 6) begin
      step();
      n++;
    end
    checks++;
    if (bus_if.coin_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait: got coin_out %b expected 1 within 6",
               bus_if.coin_out);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if ({bus_if.coin_out, bus_if.coin_busy} !== 2'b00 ||
        bus_if.coin_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got out %b busy %b count %0d expected 0",
               bus_if.coin_out, bus_if.coin_busy, bus_if.coin_count);
    end
    bus_if.joy = '0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_same_cycle();
    int rises;
    logic prev;
    do_reset();
    rises = 0;
    prev = 1'b0;
    send_key(1'b1, 1'b0, 8'h2E);
    bus_if.joy = 16'h0080;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_if.coin_out && !prev) rises++;
      prev = bus_if.coin_out;
    end
    checks++;
    if (rises !== 1 || bus_if.coin_count !== 8'd1) begin
      errors++;
      $display("FAIL same_cycle: got %0d pulses count %0d expected 1/1",
               rises, bus_if.coin_count);
    end
    send_key(1'b0, 1'b0, 8'h2E);
    bus_if.joy = '0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (bus_if.coin_busy !== 1'b0) begin
      errors++;
      $display("FAIL same_release: got busy %b expected 0",
               bus_if.coin_busy);
    end
  endtask

  task automatic test_autofire();
    logic exp;
    do_reset();
    bus_if.autofire_en = 1'b1;
    bus_if.joy = 16'h0010;
    for (int i = 0; i < 9; i++) begin
`ifdef INPUT_AUTOFIRE_EN
      exp = ((i / 3) % 2) == 0;
`else
      exp = 1'b1;
`endif
      step();
      checks++;
      if ({bus_if.p1_ctrl[4], bus_if.p2_ctrl[4]} !== {exp, exp}) begin
        errors++;
        $display("FAIL autofire i=%0d: got %b expected %b", i,
                 {bus_if.p1_ctrl[4], bus_if.p2_ctrl[4]}, {exp, exp});
      end
    end
    bus_if.autofire_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus_if.p1_ctrl !== 5'b10000) begin
        errors++;
        $display("FAIL fire_steady i=%0d: got %b expected 10000", i,
                 bus_if.p1_ctrl);
      end
    end
    bus_if.joy = '0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus_if.ps2_key = '0;
    bus_if.joy = '0;
    bus_if.autofire_en = 1'b0;
    test_reset();
    test_key_up();
    test_random_ctrl();
    test_coin_hold();
    test_holdoff();
    test_reset_mid_pulse();
    test_same_cycle();
    test_autofire();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
